// File: rtl/ysyx_23060124_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter with a single outstanding transaction.
// The winning request is latched at grant; a silent slave is answered with an error after TIMEOUT cycles.
module ysyx_23060124_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LSU_PRIO = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int TMO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic              grant_lsu;
  logic              tmo_hit;
  logic              owner_resp_ready;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_data;

  // On a conflict the LSU wins under fixed priority, otherwise whoever was not served last.
  assign grant_lsu = lsu_req_valid &&
                     (!ifu_req_valid || (LSU_PRIO != 0) || (last_owner_q == OWNER_IFU));
  assign tmo_hit          = (TIMEOUT > 0) && (tmo_cnt_q == TMO_MAX);
  assign owner_resp_ready = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    tmo_cnt_d      = tmo_cnt_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_data      = '0;

    // Handshake outputs stay quiet while reset is asserted so no master sees a phantom grant.
    if (!i_rst) begin
      case (state_q)
        S_IDLE: begin
          if (ifu_req_valid || lsu_req_valid) begin
            ifu_req_ready = !grant_lsu;
            lsu_req_ready = grant_lsu;
            owner_d       = grant_lsu ? OWNER_LSU : OWNER_IFU;
            state_d       = S_REQ;
            if (grant_lsu) begin
              addr_d  = lsu_addr;
              wen_d   = lsu_wen;
              wdata_d = lsu_wdata;
              wstrb_d = lsu_wstrb;
            end else begin
              addr_d  = ifu_addr;
              wen_d   = 1'b0;
              wdata_d = '0;
              wstrb_d = '1;
            end
          end
        end
        S_REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            state_d   = S_RESP;
            tmo_cnt_d = '0;
          end
        end
        S_RESP: begin
          if (tmo_hit) begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
          end else begin
            resp_valid     = mem_resp_valid;
            resp_data      = mem_rdata;
            mem_resp_ready = owner_resp_ready;
            if (!mem_resp_valid && (TIMEOUT > 0)) tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
          if (resp_valid && owner_resp_ready) begin
            state_d      = S_IDLE;
            last_owner_d = owner_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ifu_resp_valid = resp_valid && (owner_q == OWNER_IFU);
  assign ifu_err        = resp_err && (owner_q == OWNER_IFU);
  assign ifu_rdata      = (owner_q == OWNER_IFU) ? resp_data : '0;
  assign lsu_resp_valid = resp_valid && (owner_q == OWNER_LSU);
  assign lsu_err        = resp_err && (owner_q == OWNER_LSU);
  assign lsu_rdata      = (owner_q == OWNER_LSU) ? resp_data : '0;

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_IFU;
      last_owner_q <= OWNER_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: a fixed-priority instance with an 8-cycle timeout,
// plus a round-robin instance with the timeout disabled.
module tb_ysyx_23060124_mem_arbiter;

  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-priority instance
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  // Round-robin instance
  logic        rst_b;
  logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_ready, b_ifu_err;
  logic [31:0] b_ifu_addr, b_ifu_rdata;
  logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen, b_lsu_resp_valid, b_lsu_resp_ready, b_lsu_err;
  logic [31:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
  logic [3:0]  b_lsu_wstrb;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_wen, b_mem_resp_valid, b_mem_resp_ready;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;

  ysyx_23060124_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  ysyx_23060124_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(0), .TIMEOUT(0)) dut_rr (
    .i_clk(clk), .i_rst(rst_b),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_ready(b_ifu_resp_ready), .ifu_rdata(b_ifu_rdata),
    .ifu_err(b_ifu_err),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(b_lsu_addr),
    .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata), .lsu_wstrb(b_lsu_wstrb),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_ready(b_lsu_resp_ready), .lsu_rdata(b_lsu_rdata),
    .lsu_err(b_lsu_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_addr(b_mem_addr),
    .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_resp_valid(b_mem_resp_valid), .mem_resp_ready(b_mem_resp_ready), .mem_rdata(b_mem_rdata)
  );

  typedef struct {
    logic        ifu_v;
    logic        lsu_v;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        lsu_wen;
    logic [3:0]  wstrb;
    int          req_dly;
    int          resp_dly;
    int          rr_dly;
    logic        exp_lsu;
    logic        exp_err;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference rules: fixed priority means the LSU wins whenever it asks; a slave that stays
  // silent for TMO or more RESP cycles is answered with an error.
  function automatic logic model_lsu_wins(input logic ifu_v, input logic lsu_v);
    return lsu_v;
  endfunction

  function automatic logic model_err(input int resp_dly);
    return resp_dly >= TMO;
  endfunction

  // One full transaction on the fixed-priority instance: grant, stalled request, response.
  task automatic do_txn(input vec_t v);
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic        e_wen, own_rdy, tmo, e_valid, done;
    logic        o_valid, o_err, n_valid, n_err;
    logic [31:0] o_rdata;
    ifu_req_valid = v.ifu_v;
    lsu_req_valid = v.lsu_v;
    ifu_addr      = v.ifu_addr;
    lsu_addr      = v.lsu_addr;
    lsu_wen       = v.lsu_wen;
    lsu_wdata     = v.wdata;
    lsu_wstrb     = v.wstrb;
    @(negedge clk);
    check("idle_mem_req_valid", 64'(mem_req_valid), 64'(0));
    if (!v.ifu_v && !v.lsu_v) begin
      check("idle_ifu_req_ready", 64'(ifu_req_ready), 64'(0));
      check("idle_lsu_req_ready", 64'(lsu_req_ready), 64'(0));
      cyc();
      return;
    end
    check("grant_ifu_req_ready", 64'(ifu_req_ready), 64'(!v.exp_lsu));
    check("grant_lsu_req_ready", 64'(lsu_req_ready), 64'(v.exp_lsu));
    e_addr  = v.exp_lsu ? v.lsu_addr : v.ifu_addr;
    e_wen   = v.exp_lsu ? v.lsu_wen : 1'b0;
    e_wstrb = v.exp_lsu ? v.wstrb : 4'hF;
    cyc();

    // Request phase: upstream inputs wander, the latched copy must not.
    for (int c = 0; c <= v.req_dly; c++) begin
      ifu_req_valid = 1'($urandom_range(0, 1));
      lsu_req_valid = 1'($urandom_range(0, 1));
      ifu_addr      = $urandom;
      lsu_addr      = $urandom;
      lsu_wdata     = $urandom;
      lsu_wen       = 1'($urandom_range(0, 1));
      lsu_wstrb     = 4'($urandom_range(0, 15));
      mem_req_ready = (c == v.req_dly);
      @(negedge clk);
      check("req_mem_req_valid", 64'(mem_req_valid), 64'(1));
      check("req_mem_addr", 64'(mem_addr), 64'(e_addr));
      check("req_mem_wen", 64'(mem_wen), 64'(e_wen));
      check("req_mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
      if (v.exp_lsu) check("req_mem_wdata", 64'(mem_wdata), 64'(v.wdata));
      check("req_no_upstream_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'(0));
      cyc();
    end
    mem_req_ready = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // Response phase, bounded so a stuck DUT still reaches the summary.
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_resp_valid = (c >= v.resp_dly);
      mem_rdata      = mem_resp_valid ? v.rdata : $urandom;
      own_rdy        = (c >= v.rr_dly);
      ifu_resp_ready = v.exp_lsu ? 1'($urandom_range(0, 1)) : own_rdy;
      lsu_resp_ready = v.exp_lsu ? own_rdy : 1'($urandom_range(0, 1));
      tmo            = (c >= TMO) && v.exp_err;
      e_valid        = tmo || mem_resp_valid;
      @(negedge clk);
      o_valid = v.exp_lsu ? lsu_resp_valid : ifu_resp_valid;
      o_err   = v.exp_lsu ? lsu_err : ifu_err;
      o_rdata = v.exp_lsu ? lsu_rdata : ifu_rdata;
      n_valid = v.exp_lsu ? ifu_resp_valid : lsu_resp_valid;
      n_err   = v.exp_lsu ? ifu_err : lsu_err;
      check("resp_mem_req_valid", 64'(mem_req_valid), 64'(0));
      check("resp_mem_resp_ready", 64'(mem_resp_ready), 64'(tmo ? 1'b0 : own_rdy));
      check("resp_owner_valid", 64'(o_valid), 64'(e_valid));
      check("resp_other_valid", 64'({n_valid, n_err}), 64'(0));
      if (e_valid) begin
        check("resp_owner_err", 64'(o_err), 64'(tmo));
        check("resp_owner_rdata", 64'(o_rdata), 64'(tmo ? 32'h0 : v.rdata));
      end
      done = e_valid && own_rdy;
      cyc();
    end
    check("resp_handshake_reached", 64'(done), 64'(1));
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b0;
    lsu_resp_ready = 1'b0;
  endtask

  vec_t       tbl[10];
  vec_t       rv;
  logic       grants[$];
  logic       exp_g;
  int         cnt;
  int unsigned sz, off;

  initial begin
    // Directed vectors: {ifu_v, lsu_v, ifu_addr, lsu_addr, wdata, rdata, wen, wstrb,
    //                    req_dly, resp_dly, rr_dly, exp_lsu, exp_err}
    tbl[0] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 32'h0000_0413, 1'b0, 4'h0, 0, 2, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 1'b1, 4'b1000, 0, 1, 1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_1000, 32'h0, 32'hCAFE_F00D, 1'b0, 4'hF, 0, 0, 0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 32'h0010_0093, 1'b0, 4'h0, 0, 0, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'h8000_2000, 32'h0, 32'h1234_5678, 1'b0, 4'hF, 5, 1, 0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h8000_0008, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'h0, 0, 11, 13, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h0, 32'h8000_3000, 32'hA5A5_A5A5, 32'h0, 1'b1, 4'hF, 0, 0, 0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 0, 0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 32'h0, 32'h8000_4002, 32'h0, 32'h5555_AAAA, 1'b0, 4'b1100, 1, 7, 0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 32'h8000_000C, 32'h0, 32'h0, 32'h7777_7777, 1'b0, 4'h0, 0, 8, 9, 1'b0, 1'b1};

    rst = 1'b1; rst_b = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    b_ifu_req_valid = 0; b_ifu_addr = 32'h8000_0000; b_ifu_resp_ready = 1;
    b_lsu_req_valid = 0; b_lsu_addr = 32'h8000_1000; b_lsu_wen = 0; b_lsu_wdata = 0;
    b_lsu_wstrb = 4'hF; b_lsu_resp_ready = 1;
    b_mem_req_ready = 1; b_mem_resp_valid = 1; b_mem_rdata = 32'h0BAD_0BAD;
    cyc(); cyc();
    rst = 1'b0; rst_b = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valids", 64'({ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                             mem_req_valid, mem_resp_ready, ifu_err, lsu_err}), 64'(0));
    check("rst_mem_fields", 64'({mem_wen, mem_wstrb, mem_addr}), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'({ifu_rdata, lsu_rdata}), 64'(0));
    cyc();

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // Reset pulsed while a response is pending
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    cyc();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    ifu_resp_ready = 1'b1; ifu_req_valid = 1'b1;
    @(negedge clk);
    check("rst_in_resp_no_grant", 64'({ifu_req_ready, ifu_resp_valid}), 64'(0));
    cyc();
    rst = 1'b0; ifu_req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_quiet", 64'({ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
                                 mem_req_valid, mem_resp_ready}), 64'(0));
    cyc();
    mem_resp_valid = 1'b0; ifu_resp_ready = 1'b0;
    rv = '{1'b1, 1'b0, 32'h8000_0200, 32'h0, 32'h0, 32'h0000_0013, 1'b0, 4'h0, 0, 1, 0, 1'b0, 1'b0};
    do_txn(rv);

    // Random transactions against the reference rules
    for (int i = 0; i < 40; i++) begin
      rv.ifu_v    = 1'($urandom_range(0, 1));
      rv.lsu_v    = 1'($urandom_range(0, 1));
      rv.ifu_addr = $urandom & 32'hFFFF_FFFC;
      rv.lsu_addr = $urandom;
      rv.wdata    = $urandom;
      rv.rdata    = $urandom;
      rv.lsu_wen  = 1'($urandom_range(0, 1));
      sz          = $urandom_range(0, 2);
      off         = $urandom_range(0, 3);
      rv.wstrb    = (sz == 0) ? 4'(4'b0001 << off) :
                    (sz == 1) ? 4'(4'b0011 << (off & 2)) : 4'hF;
      rv.req_dly  = int'($urandom_range(0, 3));
      rv.resp_dly = int'($urandom_range(0, 10));
      rv.rr_dly   = int'($urandom_range(0, 3));
      rv.exp_lsu  = model_lsu_wins(rv.ifu_v, rv.lsu_v);
      rv.exp_err  = model_err(rv.resp_dly);
      do_txn(rv);
    end

    // Round-robin instance: an LSU-only grant, then both held valid.
    b_lsu_req_valid = 1'b1;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      @(negedge clk);
      if (b_ifu_req_ready || b_lsu_req_ready) begin
        check("rr_single_grant", 64'(b_ifu_req_ready && b_lsu_req_ready), 64'(0));
        grants.push_back(b_lsu_req_ready);
      end
      cyc();
      if (grants.size() >= 1) b_ifu_req_valid = 1'b1;
    end
    check("rr_grant_count", 64'(grants.size()), 64'(4));
    exp_g = 1'b1;
    foreach (grants[i]) begin
      check($sformatf("rr_grant_%0d_is_lsu", i), 64'(grants[i]), 64'(exp_g));
      exp_g = !exp_g;
    end
    b_ifu_req_valid = 1'b0; b_lsu_req_valid = 1'b0;
    repeat (4) cyc();

    // Timeout disabled: a silent slave never produces a response.
    b_mem_resp_valid = 1'b0; b_ifu_req_valid = 1'b1;
    cyc();
    b_ifu_req_valid = 1'b0;
    cyc();
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_ifu_resp_valid || b_ifu_err) cnt++;
      cyc();
    end
    check("rr_no_timeout_resp", 64'(cnt), 64'(0));
    b_mem_resp_valid = 1'b1;
    @(negedge clk);
    check("rr_late_resp_delivered", 64'({b_ifu_resp_valid, b_ifu_rdata}), {31'h0, 1'b1, 32'h0BAD_0BAD});
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
